// File: rtl/datapath_ctrl.sv
// datapath_ctrl: sequencing FSM for the lab datapath (regfile, shifter, ALU, status Z).
// Accepts one 16-bit instruction per s/w handshake into IR, then steps the
// datapath controls cycle by cycle.
// Ports:
//   clk, reset            clock, async active-high reset
//   in[15:0], s           instruction and start request (sampled only in WAIT)
//   w                     ready, high only in WAIT
//   readnum, writenum     register-file read/write addresses
//   write                 register-file write strobe
//   loada/b/c, loads      pipeline and status register loads
//   asel, bsel            A forced to 0 / B from shifter (bsel always 0)
//   vsel[1:0]             write-back source (00 = C, 10 = sximm8)
//   ALUop[1:0], shift[1:0] ALU operation and shifter control
//   sximm8, sximm5        sign-extended IR immediates
//   illegal               one-cycle pulse on an undecodable instruction
module datapath_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        illegal
);

  localparam int unsigned IW = 16;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GETA   = 3'd2,
    S_GETB   = 3'd3,
    S_EXEC   = 3'd4,
    S_WREG   = 3'd5,
    S_WIMM   = 3'd6
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] ir;

  // IR field views
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  // Instruction classes
  logic is_movi;
  logic is_movr;
  logic is_alu;
  logic is_mvn;
  logic is_cmp;

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_cmp  = is_alu && (op == 2'b01);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register: loaded only on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else if (state == S_WAIT && s) begin
      ir <= in;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:   if (s) state_next = S_DECODE;
      S_DECODE: begin
        if (is_movi)               state_next = S_WIMM;
        else if (is_movr || is_mvn) state_next = S_GETB;
        else if (is_alu)           state_next = S_GETA;
        else                       state_next = S_WAIT;
      end
      S_GETA:   state_next = S_GETB;
      S_GETB:   state_next = S_EXEC;
      S_EXEC:   state_next = is_cmp ? S_WAIT : S_WREG;
      S_WREG:   state_next = S_WAIT;
      S_WIMM:   state_next = S_WAIT;
      default:  state_next = S_WAIT;
    endcase
  end

  // Moore output decode from state and IR
  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    ALUop    = 2'b00;
    shift    = 2'b00;
    illegal  = 1'b0;
    case (state)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = !(is_movi || is_movr || is_alu);
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = sh;
      end
      S_EXEC: begin
        shift = sh;
        // MOV reg computes 0 + sh(Rm) through the adder
        ALUop = is_alu ? op : 2'b00;
        asel  = is_movr;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WREG: begin
        writenum = rd;
        vsel     = 2'b00;
        write    = 1'b1;
      end
      S_WIMM: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: the driver pushes the expected per-cycle
// control pattern of each accepted instruction; a negedge monitor pops and
// compares every cycle, expecting the idle pattern when nothing is queued.
module tb_datapath_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        illegal;

  datapath_ctrl dut (
    .clk(clk), .reset(reset), .in(in), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift),
    .sximm8(sximm8), .sximm5(sximm5), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic        illegal;
  } rec_t;

  rec_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          busy     = 0;
  int          cyc      = 0;
  logic [15:0] model_ir = 16'h0000;

  function automatic rec_t base_rec(input logic [15:0] i);
    rec_t r;
    r = '0;
    r.sximm8 = {{8{i[7]}}, i[7:0]};
    r.sximm5 = {{11{i[4]}}, i[4:0]};
    return r;
  endfunction

  function automatic rec_t idle_rec(input logic [15:0] i);
    rec_t r;
    r = base_rec(i);
    r.w = 1'b1;
    return r;
  endfunction

  // Reference: the non-WAIT cycles an instruction occupies, described by
  // instruction class. Returns the cycle count from accept to w returning.
  function automatic int model_push(input logic [15:0] i);
    rec_t b;
    rec_t r;
    logic [1:0] op;
    logic movi, movr, alu, cmp, needs_a;
    int n;
    op   = i[12:11];
    movi = (i[15:11] == 5'b11010);
    movr = (i[15:11] == 5'b11000);
    alu  = (i[15:13] == 3'b101);
    cmp  = alu && (op == 2'b01);
    needs_a = alu && (op != 2'b11);
    b = base_rec(i);
    if (movi) begin
      exp_q.push_back(b);
      r = b; r.write = 1'b1; r.writenum = i[10:8]; r.vsel = 2'b10;
      exp_q.push_back(r);
      n = 3;
    end else if (movr || alu) begin
      exp_q.push_back(b);
      n = 2;
      if (needs_a) begin
        r = b; r.readnum = i[10:8]; r.loada = 1'b1;
        exp_q.push_back(r);
        n++;
      end
      r = b; r.readnum = i[2:0]; r.loadb = 1'b1; r.shift = i[4:3];
      exp_q.push_back(r);
      r = b; r.shift = i[4:3]; r.aluop = alu ? op : 2'b00; r.asel = movr;
      r.loads = cmp; r.loadc = !cmp;
      exp_q.push_back(r);
      n += 2;
      if (!cmp) begin
        r = b; r.writenum = i[7:5]; r.write = 1'b1;
        exp_q.push_back(r);
        n++;
      end
    end else begin
      r = b; r.illegal = 1'b1;
      exp_q.push_back(r);
      n = 2;
    end
    return n;
  endfunction

  task automatic check1(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own state
  task automatic step(input logic sv, input logic [15:0] iv);
    s  = sv;
    in = iv;
    @(posedge clk);
    if (!reset) begin
      if (busy == 0 && sv) begin
        busy = model_push(iv) - 1;
        model_ir = iv;
      end else if (busy > 0) begin
        busy--;
      end
    end
    #1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0:       r[15:11] = 5'b11010;
      1:       r[15:11] = 5'b11000;
      2, 3:    r[15:13] = 3'b101;
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: compare the full control pattern every cycle
  always @(negedge clk) begin : mon
    rec_t act;
    rec_t expv;
    cyc++;
    act.w = w; act.readnum = readnum; act.writenum = writenum; act.write = write;
    act.loada = loada; act.loadb = loadb; act.loadc = loadc; act.loads = loads;
    act.asel = asel; act.bsel = bsel; act.vsel = vsel; act.aluop = ALUop;
    act.shift = shift; act.sximm8 = sximm8; act.sximm5 = sximm5; act.illegal = illegal;
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    else                  expv = idle_rec(model_ir);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL scoreboard cycle=%0d actual=%h required=%h", cyc, act, expv);
    end
  end

  initial begin
    reset = 1'b1;
    s     = 1'b0;
    in    = 16'h0000;
    #2;
    check1("reset_w", 16'(w), 16'h0001);
    check1("reset_write", 16'(write), 16'h0000);
    check1("reset_sximm8", sximm8, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 16'h0000);

    // Directed instructions from the test plan, with gaps between them
    step(1'b1, 16'hD0FB);   // MOV R0,#-5
    repeat (4) step(1'b0, 16'($urandom));
    step(1'b1, 16'hA148);   // ADD R2,R1,R0 LSL #1
    repeat (6) step(1'b0, 16'($urandom));
    step(1'b1, 16'hAB04);   // CMP R3,R4
    repeat (5) step(1'b0, 16'($urandom));
    step(1'b1, 16'hB8A6);   // MVN R5,R6
    repeat (5) step(1'b0, 16'($urandom));
    step(1'b1, 16'hE000);   // illegal
    repeat (3) step(1'b0, 16'($urandom));

    // Reset during GETB of an ADD
    step(1'b1, 16'hA148);   // now in DECODE
    step(1'b0, 16'($urandom)); // GETA
    step(1'b0, 16'($urandom)); // GETB
    check1("getb_loadb", 16'(loadb), 16'h0001);
    check1("getb_readnum", 16'(readnum), 16'h0000);
    reset = 1'b1;
    exp_q.delete();
    busy = 0;
    model_ir = 16'h0000;
    #1;
    check1("rst_loadb", 16'(loadb), 16'h0000);
    check1("rst_w", 16'(w), 16'h0001);
    step(1'b1, 16'hD0FB);   // ignored while reset held
    reset = 1'b0;
    step(1'b0, 16'h0000);

    // Back-to-back MOV imm with s held high
    step(1'b1, 16'hD0FB);
    repeat (3) step(1'b1, 16'hD105);
    repeat (4) step(1'b0, 16'($urandom));

    // Randomized traffic; in changes every cycle, including mid-instruction
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 3) != 0), rand_instr());
    end

    // Drain
    repeat (8) step(1'b0, 16'($urandom));
    check1("drain_queue", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
